// File: rtl/branch_unit_bht_if.sv
// ---------------------------------------------------------------------------
// branch_unit_bht_if
//   Bundle of the signals that run between the pipeline and the branch
//   resolution unit. It carries the fetch-side prediction lookup, the EX-side
//   resolution request and the registered resolution result.
//
//   Modports:
//     master : pipeline side. It drives the lookup PC and the EX branch, and
//              receives the prediction and the result.
//     slave  : branch unit side.
//
//   Optional macro BRANCH_UNIT_STATS_EN adds the stat_branches and
//   stat_mispredicts counters as slave outputs.
//
//   Signals:
//     if_pc, if_pred_taken             fetch-stage lookup and prediction
//     ex_valid, ex_funct3, ex_rs1,
//     ex_rs2, ex_pc, ex_pred_taken,
//     flush                            EX-stage branch to resolve
//     res_valid, res_taken,
//     res_mispredict, res_illegal      registered resolution result
// ---------------------------------------------------------------------------
interface branch_unit_bht_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;

  logic            ex_valid;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic [XLEN-1:0] ex_pc;
  logic            ex_pred_taken;
  logic            flush;

  logic            res_valid;
  logic            res_taken;
  logic            res_mispredict;
  logic            res_illegal;

`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;

  modport master (
    output if_pc, ex_valid, ex_funct3, ex_rs1, ex_rs2, ex_pc, ex_pred_taken, flush,
    input  if_pred_taken, res_valid, res_taken, res_mispredict, res_illegal,
    input  stat_branches, stat_mispredicts
  );

  modport slave (
    input  if_pc, ex_valid, ex_funct3, ex_rs1, ex_rs2, ex_pc, ex_pred_taken, flush,
    output if_pred_taken, res_valid, res_taken, res_mispredict, res_illegal,
    output stat_branches, stat_mispredicts
  );
`else
  modport master (
    output if_pc, ex_valid, ex_funct3, ex_rs1, ex_rs2, ex_pc, ex_pred_taken, flush,
    input  if_pred_taken, res_valid, res_taken, res_mispredict, res_illegal
  );

  modport slave (
    input  if_pc, ex_valid, ex_funct3, ex_rs1, ex_rs2, ex_pc, ex_pred_taken, flush,
    output if_pred_taken, res_valid, res_taken, res_mispredict, res_illegal
  );
`endif

endinterface

// File: rtl/branch_unit_bht.sv
// ---------------------------------------------------------------------------
// branch_unit_bht
//   Resolves the six RV32I conditional branches from raw operands and
//   registers the outcome with one cycle of latency. The result is compared
//   with the prediction that fetch made, so a misprediction can drive the
//   redirect and flush logic. The unit also holds a table of 2-bit saturating
//   counters. Resolved branches train the table, and fetch reads it in the
//   same cycle to get a direction prediction.
//
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : branch_unit_bht_if.slave
//            inputs  if_pc, ex_valid, ex_funct3, ex_rs1, ex_rs2, ex_pc,
//                    ex_pred_taken, flush
//            outputs if_pred_taken (combinational), res_valid, res_taken,
//                    res_mispredict, res_illegal (registered)
//
//   Parameters:
//     XLEN        : operand and PC width
//     BHT_ENTRIES : number of counters; must be a power of two, >= 4
//     IDX_W       : derived index width; the table is indexed by pc[IDX_W+1:2]
//
//   Optional macro BRANCH_UNIT_STATS_EN adds two saturating 32-bit event
//   counters, stat_branches and stat_mispredicts, on the interface. When the
//   macro is undefined, these counters do not exist.
// ---------------------------------------------------------------------------
module branch_unit_bht #(
  parameter  int XLEN        = 32,
  parameter  int BHT_ENTRIES = 64,
  localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input logic               clk,
  input logic               rst,
  branch_unit_bht_if.slave  bus
);

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
  localparam logic [1:0] CTR_RESET = 2'b01;

  // ---------------------------------------------------------------------
  // Condition evaluation
  // ---------------------------------------------------------------------
  logic eq;
  logic lt_s;
  logic lt_u;
  logic taken;
  logic illegal;

  assign eq   = (bus.ex_rs1 == bus.ex_rs2);
  assign lt_s = ($signed(bus.ex_rs1) < $signed(bus.ex_rs2));
  assign lt_u = (bus.ex_rs1 < bus.ex_rs2);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (bus.ex_funct3)
      3'b000:  taken = eq;      // BEQ
      3'b001:  taken = ~eq;     // BNE
      3'b100:  taken = lt_s;    // BLT
      3'b101:  taken = ~lt_s;   // BGE
      3'b110:  taken = lt_u;    // BLTU
      3'b111:  taken = ~lt_u;   // BGEU
      default: illegal = 1'b1;  // 010 / 011 are not branch encodings
    endcase
  end

  logic accept;
  assign accept = bus.ex_valid & ~bus.flush;

  // ---------------------------------------------------------------------
  // Registered result
  // ---------------------------------------------------------------------
  logic res_valid_q,      res_valid_d;
  logic res_taken_q,      res_taken_d;
  logic res_illegal_q,    res_illegal_d;
  logic res_mispredict_q, res_mispredict_d;

  // Every result field is qualified with accept, so an idle or flushed cycle
  // clears the outputs instead of holding the previous result.
  always_comb begin
    res_valid_d      = accept;
    res_taken_d      = taken & accept;
    res_illegal_d    = illegal & accept;
    res_mispredict_d = accept & ~illegal & (taken != bus.ex_pred_taken);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_illegal_q    <= 1'b0;
      res_mispredict_q <= 1'b0;
    end else begin
      res_valid_q      <= res_valid_d;
      res_taken_q      <= res_taken_d;
      res_illegal_q    <= res_illegal_d;
      res_mispredict_q <= res_mispredict_d;
    end
  end

  assign bus.res_valid      = res_valid_q;
  assign bus.res_taken      = res_taken_q;
  assign bus.res_illegal    = res_illegal_q;
  assign bus.res_mispredict = res_mispredict_q;

  // ---------------------------------------------------------------------
  // Branch history table
  //   The whole table must clear on reset, so it is built from individual
  //   flops rather than a RAM. Each entry is a small register that loads only
  //   when it is the addressed update target.
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_en;
  logic [1:0]       upd_cur;
  logic [1:0]       upd_ctr_d;
  logic [1:0]       ctr_all [BHT_ENTRIES];

  // PC bits [1:0] are dropped. Higher bits are ignored, so aliasing PCs
  // intentionally share a counter.
  assign if_idx  = bus.if_pc[IDX_W+1:2];
  assign upd_idx = bus.ex_pc[IDX_W+1:2];
  assign upd_en  = accept & ~illegal;
  assign upd_cur = ctr_all[upd_idx];

  always_comb begin
    upd_ctr_d = upd_cur;
    if (taken) begin
      if (upd_cur != 2'b11) upd_ctr_d = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_ctr_d = upd_cur - 2'b01;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
      logic [1:0] ctr_q;
      logic       hit;

      assign hit = upd_en && (upd_idx == IDX_W'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ctr_q <= CTR_RESET;
        end else if (hit) begin
          ctr_q <= upd_ctr_d;
        end
      end

      assign ctr_all[gi] = ctr_q;
    end
  endgenerate

  // The lookup reads the current flop contents. When the lookup and the
  // update hit the same entry, fetch therefore sees the pre-update value, and
  // the trained value appears on the next cycle.
  assign bus.if_pred_taken = ctr_all[if_idx][1];

  // ---------------------------------------------------------------------
  // Optional event counters
  // ---------------------------------------------------------------------
`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0] stat_branches_q,    stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (upd_en && (stat_branches_q != 32'hFFFF_FFFF)) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end
    if (res_mispredict_d && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign bus.stat_branches    = stat_branches_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;
`endif

  // PC bits outside the index field are deliberately unused.
  logic unused_pc_bits;
  generate
    if (XLEN > IDX_W + 2) begin : g_unused_hi
      assign unused_pc_bits = ^{bus.if_pc[XLEN-1:IDX_W+2], bus.if_pc[1:0],
                                bus.ex_pc[XLEN-1:IDX_W+2], bus.ex_pc[1:0]};
    end else begin : g_unused_lo
      assign unused_pc_bits = ^{bus.if_pc[1:0], bus.ex_pc[1:0]};
    end
  endgenerate

endmodule

// File: tb/tb_branch_unit_bht.sv
// ---------------------------------------------------------------------------
// tb_branch_unit_bht
//   Self-checking bench for branch_unit_bht. It drives the unit through the
//   interface and predicts every output from a behavioural model. The model
//   holds an integer array of counters and computes branch conditions with
//   plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_branch_unit_bht;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_unit_bht_if #(.XLEN(XLEN)) bus ();

  branch_unit_bht #(.XLEN(XLEN), .BHT_ENTRIES(ENTRIES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  int      model_ctr [ENTRIES];
  longint  exp_branches;
  longint  exp_misp;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    bit          pred;
    bit          exp_taken;
    bit          exp_ill;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit ref_illegal(input logic [2:0] f3);
    return (f3 == 3'd2) || (f3 == 3'd3);
  endfunction

  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) model_ctr[i] = 1;
    exp_branches = 0;
    exp_misp     = 0;
  endtask

  // One transaction. The task is entered just after a rising edge. It drives
  // the inputs, checks the combinational prediction, clocks once, and then
  // checks the registered result against the model.
  task automatic do_cycle(input string tag, input bit v, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                          input bit pred, input bit fl, input logic [31:0] ipc);
    bit acc, ill, tk, misp;
    bus.ex_valid      = v;
    bus.ex_funct3     = f3;
    bus.ex_rs1        = a;
    bus.ex_rs2        = b;
    bus.ex_pc         = pc;
    bus.ex_pred_taken = pred;
    bus.flush         = fl;
    bus.if_pc         = ipc;
    #1;
    check({tag, " if_pred_taken"}, 32'(bus.if_pred_taken), 32'(model_ctr[idx_of(ipc)] >= 2));
    acc  = v && !fl;
    ill  = ref_illegal(f3);
    tk   = ref_taken(f3, a, b);
    misp = acc && !ill && (tk != pred);
    @(posedge clk);
    #1;
    check({tag, " res_valid"},      32'(bus.res_valid),      32'(acc));
    check({tag, " res_taken"},      32'(bus.res_taken),      32'(acc && tk));
    check({tag, " res_illegal"},    32'(bus.res_illegal),    32'(acc && ill));
    check({tag, " res_mispredict"}, 32'(bus.res_mispredict), 32'(misp));
    if (acc && !ill) begin
      if (tk) model_ctr[idx_of(pc)] = (model_ctr[idx_of(pc)] == 3) ? 3 : model_ctr[idx_of(pc)] + 1;
      else    model_ctr[idx_of(pc)] = (model_ctr[idx_of(pc)] == 0) ? 0 : model_ctr[idx_of(pc)] - 1;
      exp_branches++;
    end
    if (misp) exp_misp++;
    $display("txn %-10s v=%0b fl=%0b f3=%0d rs1=%08h rs2=%08h pc=%08h pred=%0b -> valid=%0b taken=%0b ill=%0b misp=%0b",
             tag, v, fl, f3, a, b, pc, pred, bus.res_valid, bus.res_taken, bus.res_illegal, bus.res_mispredict);
  endtask

  task automatic idle(input string tag, input logic [31:0] ipc);
    do_cycle(tag, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, ipc);
  endtask

  task automatic random_phase(input int n);
    logic [31:0] a, b, pc, ipc;
    logic [2:0]  f3;
    bit          v, fl, pred;
    for (int i = 0; i < n; i++) begin
      a    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      b    = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 4)) : $urandom);
      f3   = 3'($urandom_range(0, 7));
      v    = ($urandom_range(0, 4) != 0);
      fl   = ($urandom_range(0, 5) == 0);
      pred = 1'($urandom_range(0, 1));
      pc   = 32'($urandom_range(0, 255)) << 2;
      ipc  = ($urandom_range(0, 3) == 0) ? pc : (32'($urandom_range(0, 255)) << 2);
      do_cycle("random", v, f3, a, b, pc, pred, fl, ipc);
    end
  endtask

  initial begin
    model_reset();
    bus.if_pc = 0; bus.ex_valid = 0; bus.ex_funct3 = 0; bus.ex_rs1 = 0; bus.ex_rs2 = 0;
    bus.ex_pc = 0; bus.ex_pred_taken = 0; bus.flush = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.if_pc = 32'h0;  #1 check("reset pred pc0",  32'(bus.if_pred_taken), 32'd0);
    bus.if_pc = 32'h4;  #1 check("reset pred pc4",  32'(bus.if_pred_taken), 32'd0);
    bus.if_pc = 32'hFC; #1 check("reset pred pcFC", 32'(bus.if_pred_taken), 32'd0);
    check("reset res_*", {28'd0, bus.res_valid, bus.res_taken, bus.res_illegal, bus.res_mispredict}, 32'd0);
    @(posedge clk); #1;

    // Table-driven condition vectors
    vecs[0] = '{3'd4, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b1, 1'b0}; // BLT  -1 < 1
    vecs[1] = '{3'd6, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0}; // BLTU big !< 1
    vecs[2] = '{3'd0, 32'd5,         32'd5,         1'b1, 1'b1, 1'b0}; // BEQ
    vecs[3] = '{3'd1, 32'd5,         32'd5,         1'b1, 1'b0, 1'b0}; // BNE equal
    vecs[4] = '{3'd5, 32'h1,         32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0}; // BGE  1 >= -1
    vecs[5] = '{3'd7, 32'h1,         32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}; // BGEU
    vecs[6] = '{3'd5, 32'd7,         32'd7,         1'b1, 1'b1, 1'b0}; // BGE equal
    vecs[7] = '{3'd6, 32'd0,         32'd1,         1'b0, 1'b1, 1'b0}; // BLTU
    vecs[8] = '{3'd2, 32'd3,         32'd3,         1'b1, 1'b0, 1'b1}; // illegal 010
    vecs[9] = '{3'd4, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0}; // BLT min < max
    for (int i = 0; i < 10; i++) begin
      do_cycle("vector", 1'b1, vecs[i].f3, vecs[i].a, vecs[i].b, 32'h1000 + 32'(i * 4),
               vecs[i].pred, 1'b0, 32'h1000 + 32'(i * 4));
      check("vector taken",   32'(bus.res_taken),   32'(vecs[i].exp_taken));
      check("vector illegal", 32'(bus.res_illegal), 32'(vecs[i].exp_ill));
    end
    idle("idle", 32'h0);
    check("result one cycle only", 32'(bus.res_valid), 32'd0);

    // Training at 0x40, always predicted not-taken
    for (int i = 0; i < 4; i++) begin
      do_cycle("train", 1'b1, 3'd0, 32'd5, 32'd5, 32'h40, 1'b0, 1'b0, (i % 2 == 0) ? 32'h40 : 32'h140);
      check("train mispredict", 32'(bus.res_mispredict), 32'd1);
      bus.if_pc = 32'h40;  #1 check("train pred 0x40",  32'(bus.if_pred_taken), 32'd1);
      bus.if_pc = 32'h140; #1 check("train pred 0x140", 32'(bus.if_pred_taken), 32'd1);
    end

    // Lookup/update collision at 0x80
    do_cycle("collide", 1'b1, 3'd0, 32'd9, 32'd9, 32'h80, 1'b0, 1'b0, 32'h80);
    bus.ex_valid = 1'b0; #1;
    check("collide pred next", 32'(bus.if_pred_taken), 32'd1);
    @(posedge clk); #1;

    // Flushed taken BNE at 0x20 must not train
    do_cycle("flush", 1'b1, 3'd1, 32'd1, 32'd2, 32'h20, 1'b0, 1'b1, 32'h20);
    idle("postflush", 32'h20);
    check("flush no update", 32'(bus.if_pred_taken), 32'd0);

    // Illegal funct3 must not train; 0x30 is first moved to weak-taken
    do_cycle("pretrain", 1'b1, 3'd0, 32'd1, 32'd1, 32'h30, 1'b1, 1'b0, 32'h30);
    do_cycle("illegal", 1'b1, 3'd3, 32'd1, 32'd2, 32'h30, 1'b1, 1'b0, 32'h30);
    check("illegal fields", {28'd0, bus.res_valid, bus.res_taken, bus.res_illegal, bus.res_mispredict}, 32'b1010);
    idle("postill", 32'h30);
    check("illegal no update", 32'(bus.if_pred_taken), 32'd1);

    random_phase(300);

    // Asynchronous reset while a resolution is in flight
    bus.ex_valid = 1'b1; bus.ex_funct3 = 3'd0; bus.ex_rs1 = 1; bus.ex_rs2 = 1;
    bus.ex_pc = 32'h40; bus.ex_pred_taken = 1'b0; bus.flush = 1'b0; bus.if_pc = 32'h40;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("async rst res_*", {28'd0, bus.res_valid, bus.res_taken, bus.res_illegal, bus.res_mispredict}, 32'd0);
    check("async rst pred", 32'(bus.if_pred_taken), 32'd0);
    model_reset();
    bus.ex_valid = 1'b0;
    #3 rst = 1'b0;
    @(posedge clk); #1;
    random_phase(100);

`ifdef BRANCH_UNIT_STATS_EN
    check("stat_branches",    bus.stat_branches,    32'(exp_branches));
    check("stat_mispredicts", bus.stat_mispredicts, 32'(exp_misp));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Guard against a hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
